// File: rtl/bp_pkg.sv
// Shared 2-bit branch counter encoding for the predictor and the flush controller.
package bp_pkg;

    typedef logic [1:0] contador_t;

    localparam contador_t FUERTE_NT      = 2'b00;
    localparam contador_t DEBIL_NT       = 2'b01;
    localparam contador_t DEBIL_T        = 2'b10;
    localparam contador_t FUERTE_T       = 2'b11;
    localparam contador_t CONTADOR_RESET = DEBIL_NT;

    localparam int unsigned ANCHO_ESTAD = 32;

endpackage

// File: rtl/predictor_saltos_bht_if.sv
// Fetch/execute interface of the branch history table.
// Statistics ports exist only when BP_ESTADISTICAS_EN is defined.
interface predictor_saltos_bht_if
    import bp_pkg::*;
#(
    parameter int unsigned ANCHO_PC = 32
);
    logic [ANCHO_PC-1:0] pc_if_i;
    contador_t           prediccion_o;
    logic                tomar_o;
    logic                actualizar_i;
    logic [ANCHO_PC-1:0] pc_ex_i;
    logic                taken_i;
    contador_t           prediccion_ex_i;
`ifdef BP_ESTADISTICAS_EN
    logic [ANCHO_ESTAD-1:0] saltos_total_o;
    logic [ANCHO_ESTAD-1:0] fallos_o;
`endif

    modport master (
        output pc_if_i, actualizar_i, pc_ex_i, taken_i, prediccion_ex_i,
`ifdef BP_ESTADISTICAS_EN
        input  saltos_total_o, fallos_o,
`endif
        input  prediccion_o, tomar_o
    );

    modport slave (
        input  pc_if_i, actualizar_i, pc_ex_i, taken_i, prediccion_ex_i,
`ifdef BP_ESTADISTICAS_EN
        output saltos_total_o, fallos_o,
`endif
        output prediccion_o, tomar_o
    );
endinterface

// File: rtl/contador_saturado_2b.sv
// Next-state function of a 2-bit saturating branch counter.
module contador_saturado_2b
    import bp_pkg::*;
(
    input  contador_t actual,
    input  logic      taken,
    output contador_t siguiente
);
    always_comb begin
        siguiente = actual;
        if (taken && (actual != FUERTE_T)) begin
            siguiente = actual + 2'd1;
        end else if (!taken && (actual != FUERTE_NT)) begin
            siguiente = actual - 2'd1;
        end
    end
endmodule

// File: rtl/predictor_saltos_bht.sv
// Untagged branch history table of 2-bit counters: combinational read at fetch,
// training at execute. Optional statistics counters under BP_ESTADISTICAS_EN.
module predictor_saltos_bht
    import bp_pkg::*;
#(
    parameter int unsigned ENTRADAS = 64,
    parameter int unsigned ANCHO_PC = 32
)(
    input logic                  clk_i,
    input logic                  rst_i,
    predictor_saltos_bht_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRADAS);

    contador_t        r_tabla [ENTRADAS];
    logic [IDX_W-1:0] w_idx_if;
    logic [IDX_W-1:0] w_idx_ex;
    contador_t        w_actual_ex;
    contador_t        w_siguiente_ex;

    assign w_idx_if    = bus.pc_if_i[IDX_W+1:2];
    assign w_idx_ex    = bus.pc_ex_i[IDX_W+1:2];
    assign w_actual_ex = r_tabla[w_idx_ex];

    assign bus.prediccion_o = r_tabla[w_idx_if];
    assign bus.tomar_o      = bus.prediccion_o[1];

    contador_saturado_2b u_contador (
        .actual    (w_actual_ex),
        .taken     (bus.taken_i),
        .siguiente (w_siguiente_ex)
    );

    // Training reads the live entry, so aliasing branches see each other's updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRADAS); i++) begin
                r_tabla[i] <= CONTADOR_RESET;
            end
        end else if (bus.actualizar_i) begin
            r_tabla[w_idx_ex] <= w_siguiente_ex;
        end
    end

`ifdef BP_ESTADISTICAS_EN
    logic [ANCHO_ESTAD-1:0] r_saltos_total;
    logic [ANCHO_ESTAD-1:0] r_fallos;
    logic                   w_fallo;

    assign w_fallo = bus.prediccion_ex_i[1] != bus.taken_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_saltos_total <= '0;
            r_fallos       <= '0;
        end else if (bus.actualizar_i) begin
            if (r_saltos_total != '1) r_saltos_total <= r_saltos_total + ANCHO_ESTAD'(1);
            if (w_fallo && (r_fallos != '1)) r_fallos <= r_fallos + ANCHO_ESTAD'(1);
        end
    end

    assign bus.saltos_total_o = r_saltos_total;
    assign bus.fallos_o       = r_fallos;

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.pc_if_i[ANCHO_PC-1:IDX_W+2], bus.pc_if_i[1:0],
                             bus.pc_ex_i[ANCHO_PC-1:IDX_W+2], bus.pc_ex_i[1:0],
                             bus.prediccion_ex_i[0]};
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.pc_if_i[ANCHO_PC-1:IDX_W+2], bus.pc_if_i[1:0],
                             bus.pc_ex_i[ANCHO_PC-1:IDX_W+2], bus.pc_ex_i[1:0],
                             bus.prediccion_ex_i};
`endif
endmodule

// File: tb/tb_predictor_saltos_bht.sv
// Self-checking bench for predictor_saltos_bht; statistics checks run when
// BP_ESTADISTICAS_EN is defined.
module tb_predictor_saltos_bht;
    import bp_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   errores = 0;
    int   checks  = 0;
    logic [1:0] q_esperado [$];

    predictor_saltos_bht_if #(.ANCHO_PC(32)) bus ();

    predictor_saltos_bht #(.ENTRADAS(64), .ANCHO_PC(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Read a PC and compare both outputs against an expected counter.
    task automatic leer(input string tag, input logic [31:0] pc, input logic [1:0] esp);
        bus.pc_if_i = pc;
        #1;
        check({tag, "_pred"}, 32'(bus.prediccion_o), 32'(esp));
        check({tag, "_tomar"}, 32'(bus.tomar_o), 32'(esp[1]));
    endtask

    // One training cycle; the expected post-edge value is queued and popped on readback.
    task automatic entrenar(input string tag, input logic [31:0] pc, input logic tk,
                            input logic [1:0] pred_ex, input logic [1:0] esp);
        @(negedge clk_i);
        bus.actualizar_i    = 1'b1;
        bus.pc_ex_i         = pc;
        bus.taken_i         = tk;
        bus.prediccion_ex_i = pred_ex;
        q_esperado.push_back(esp);
        @(negedge clk_i);
        bus.actualizar_i = 1'b0;
        leer(tag, pc, q_esperado.pop_front());
    endtask

    initial begin
        rst_i               = 1'b1;
        bus.pc_if_i         = '0;
        bus.actualizar_i    = 1'b0;
        bus.pc_ex_i         = '0;
        bus.taken_i         = 1'b0;
        bus.prediccion_ex_i = 2'b00;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        leer("rst_0x0", 32'h0, DEBIL_NT);
        leer("rst_0x4", 32'h4, DEBIL_NT);
        leer("rst_0xfc", 32'hFC, DEBIL_NT);

        entrenar("t1", 32'h40, 1'b1, 2'b01, DEBIL_T);
        entrenar("t2", 32'h40, 1'b1, 2'b10, FUERTE_T);
        entrenar("t3", 32'h40, 1'b1, 2'b11, FUERTE_T);
        entrenar("t4", 32'h40, 1'b1, 2'b11, FUERTE_T);

        entrenar("n1", 32'h40, 1'b0, 2'b11, DEBIL_T);
        entrenar("n2", 32'h40, 1'b0, 2'b10, DEBIL_NT);
        entrenar("n3", 32'h40, 1'b0, 2'b01, FUERTE_NT);
        entrenar("n4t", 32'h40, 1'b1, 2'b00, DEBIL_NT);

        entrenar("alias_100", 32'h100, 1'b1, 2'b01, DEBIL_T);
        leer("alias_000", 32'h000, DEBIL_T);
        leer("alias_004", 32'h004, DEBIL_NT);
        // Training from the aliased entry's latest value, not from pred_ex.
        entrenar("alias_nt", 32'h000, 1'b0, 2'b11, DEBIL_NT);

        // Same-cycle read and update: old value now, new value after the edge.
        @(negedge clk_i);
        bus.pc_if_i         = 32'h20;
        bus.actualizar_i    = 1'b1;
        bus.pc_ex_i         = 32'h20;
        bus.taken_i         = 1'b1;
        bus.prediccion_ex_i = 2'b01;
        #1;
        check("mismo_ciclo_antes", 32'(bus.prediccion_o), 32'(DEBIL_NT));
        @(negedge clk_i);
        bus.actualizar_i = 1'b0;
        #1;
        check("mismo_ciclo_despues", 32'(bus.prediccion_o), 32'(DEBIL_T));

`ifdef BP_ESTADISTICAS_EN
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("estad_rst_total", bus.saltos_total_o, 32'd0);
        check("estad_rst_fallos", bus.fallos_o, 32'd0);
        entrenar("e1", 32'h80, 1'b1, 2'b11, DEBIL_T);
        entrenar("e2", 32'h80, 1'b0, 2'b11, DEBIL_NT);
        entrenar("e3", 32'h80, 1'b1, 2'b11, DEBIL_T);
        entrenar("e4", 32'h80, 1'b0, 2'b11, DEBIL_NT);
        entrenar("e5", 32'h80, 1'b1, 2'b11, DEBIL_T);
        check("estad_total", bus.saltos_total_o, 32'd5);
        check("estad_fallos", bus.fallos_o, 32'd2);
`endif

        // Reset together with an update: the update is dropped, table back to 01.
        @(negedge clk_i);
        rst_i               = 1'b1;
        bus.actualizar_i    = 1'b1;
        bus.pc_ex_i         = 32'h80;
        bus.taken_i         = 1'b1;
        bus.prediccion_ex_i = 2'b10;
        @(negedge clk_i);
        rst_i            = 1'b0;
        bus.actualizar_i = 1'b0;
        leer("rst_upd_0x80", 32'h80, DEBIL_NT);
        leer("rst_upd_0x20", 32'h20, DEBIL_NT);
        leer("rst_upd_0x40", 32'h40, DEBIL_NT);
`ifdef BP_ESTADISTICAS_EN
        check("rst_upd_total", bus.saltos_total_o, 32'd0);
        check("rst_upd_fallos", bus.fallos_o, 32'd0);
`endif

        check("cola_vacia", 32'(q_esperado.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end
endmodule

// File: doc/predictor_saltos_bht.md
# predictor_saltos_bht

Branch history table of 2-bit saturating counters that supplies the per-branch prediction used by the fetch stage. The resolved outcome from execute trains it. The 2-bit counter value read at fetch travels down the pipeline with the instruction. At execute, the flush controller compares it against the real outcome. This block is the producing and training end of that prediction path: it owns the counter state and its update rules.

## Interface
- `ENTRADAS`, default 64: number of table entries; power of two, ≥ 2.
- `ANCHO_PC`, default 32: PC width in bits.
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `pc_if_i`  in  ANCHO_PC  PC of the instruction being fetched.
- `prediccion_o`  out  2  counter value for `pc_if_i`; carried down the pipeline with the instruction.
- `tomar_o`  out  1  predicted taken; equals `prediccion_o[1]`.
- `actualizar_i`  in  1  a conditional branch resolves in execute this cycle.
- `pc_ex_i`  in  ANCHO_PC  PC of the resolving branch.
- `taken_i`  in  1  real outcome of the resolving branch.
- `prediccion_ex_i`  in  2  counter value that branch carried from fetch; used only by the statistics feature.
- `saltos_total_o`  out  32  resolved-branch count; present only with the macro.
- `fallos_o`  out  32  misprediction count; present only with the macro.

## Operation
- Index is `pc[$clog2(ENTRADAS)+1:2]`; PC bits [1:0] are ignored. There are no tags, so aliasing branches share a counter.
- Counter encoding:
  - 00 = strongly not taken
  - 01 = weakly not taken
  - 10 = weakly taken
  - 11 = strongly taken
- Read: `prediccion_o = tabla[idx(pc_if_i)]`, combinational.
- Update when `actualizar_i = 1`:
  - `taken_i = 1`: the counter at `idx(pc_ex_i)` increments, saturating at 11.
  - `taken_i = 0`: the counter decrements, saturating at 00.
- Training always uses the table's current value, never `prediccion_ex_i`. An entry already updated by an aliasing branch therefore trains from its latest state.
- Misprediction is defined as `prediccion_ex_i[1] != taken_i`. This covers both directions: predicted taken but not taken, and predicted not taken but taken.
- Reset sets every entry to 01 in the same cycle, which requires a register array (no RAM macro). Reset has priority over a simultaneous update.
- `actualizar_i = 0`: table unchanged; `pc_ex_i`, `taken_i` and `prediccion_ex_i` are don't-care.

## Timing
- Read latency 0: combinational from `pc_if_i`.
- Update latency 1: the new value is visible on `prediccion_o` the cycle after the edge that samples `actualizar_i`.
- Same-index read and update in the same cycle: no bypass. `prediccion_o` shows the old value that cycle and the new value from the next cycle.
- Reset outputs:
  - `prediccion_o` = 01 and `tomar_o` = 0 for every PC.
  - Statistics counters = 0.
- Reset asserted mid-stream: any update in that cycle is dropped, and the table is fully 01 on the following cycle.

## Configuration
- Macro `BP_ESTADISTICAS_EN`.
- Defined:
  - `saltos_total_o` increments on each `actualizar_i`.
  - `fallos_o` increments on each update where a misprediction occurs.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are registered, update on the same edge as the table, and are cleared by `rst_i`.
- Undefined: both ports and their counters are absent. `prediccion_ex_i` remains a port but has no effect.

## Structure
- Package `bp_pkg`:
  - `typedef logic [1:0] contador_t`.
  - Constants `FUERTE_NT = 2'b00`, `DEBIL_NT = 2'b01`, `DEBIL_T = 2'b10`, `FUERTE_T = 2'b11`.
  - Reset value `CONTADOR_RESET = DEBIL_NT`.
  - The flush controller imports this package so both ends share one encoding.
- Sub-module `contador_saturado_2b`: combinational next-state function (`actual`, `taken` -> `siguiente`), instantiated once on the update path.

## Test plan
- Reset, then read PCs 0x0, 0x4 and 0xFC -> `prediccion_o` = 01 and `tomar_o` = 0 for all.
- Four updates, taken = 1, at PC 0x40 -> entry 0x40 reads 10, 11, 11, 11 after each edge; `tomar_o` = 1 from the first.
- Three updates, taken = 0, at PC 0x40 from 11 -> entry reads 10, 01, 00; then one update with taken = 1 -> 01.
- With `ENTRADAS` = 64, update PC 0x100 (taken) -> PC 0x000 (same index) reads 10, while PC 0x004 stays 01.
- Same-cycle read and update of PC 0x20 with taken = 1 -> `prediccion_o` = 01 that cycle and 10 the next.
- With `BP_ESTADISTICAS_EN`:
  - Five updates carrying `prediccion_ex_i` = 11 with taken = 1, 0, 1, 0, 1 -> `saltos_total_o` = 5, `fallos_o` = 2.
  - Assert `rst_i` together with a sixth update -> both counters = 0 and that entry = 01.
